// File: rtl/read_data_router.sv
// AXI read-data router: steers the granted slave's R beats to the owning
// master through a 2-entry FIFO and enforces the requested burst length.
module read_data_router #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ar_hs,
  input  logic              ar_slave,
  input  logic [7:0]        ar_id,
  input  logic [3:0]        ar_len,
  input  logic [7:0]        RID_S0,
  input  logic [DATA_W-1:0] RDATA_S0,
  input  logic [1:0]        RRESP_S0,
  input  logic              RLAST_S0,
  input  logic              RVALID_S0,
  output logic              RREADY_S0,
  input  logic [7:0]        RID_S1,
  input  logic [DATA_W-1:0] RDATA_S1,
  input  logic [1:0]        RRESP_S1,
  input  logic              RLAST_S1,
  input  logic              RVALID_S1,
  output logic              RREADY_S1,
  output logic [3:0]        RID_M0,
  output logic [DATA_W-1:0] RDATA_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RLAST_M0,
  output logic              RVALID_M0,
  input  logic              RREADY_M0,
  output logic [3:0]        RID_M1,
  output logic [DATA_W-1:0] RDATA_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RLAST_M1,
  output logic              RVALID_M1,
  input  logic              RREADY_M1,
  output logic              R_done_M0,
  output logic              R_done_M1,
  output logic              busy,
  output logic              len_err
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [3:0]        id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } ent_t;

  state_t     state_q;
  logic       sel_s_q;
  logic       sel_m_q;
  logic [3:0] len_q;
  logic [3:0] cnt_q;
  logic       err_q;
  ent_t       buf_q [2];
  logic       wp_q;
  logic       rp_q;
  logic [1:0] occ_q;
  logic [1:0] occ_d;

  logic              full;
  logic              empty;
  logic              s_rdy;
  logic              s_vld;
  logic              s_last;
  logic [3:0]        s_id;
  logic [DATA_W-1:0] s_data;
  logic [1:0]        s_resp;
  logic              push;
  logic              pop;
  logic              last_int;
  logic              m_vld;
  logic              m_rdy;
  logic              m0_on;
  logic              m1_on;
  ent_t              head;

  logic unused;
  assign unused = ^{ar_id[3:0], RID_S0[7:4], RID_S1[7:4]};

  assign full     = occ_q[1];
  assign empty    = (occ_q == 2'd0);
  assign s_rdy    = (state_q == FILL) && !full;
  assign s_vld    = sel_s_q ? RVALID_S1 : RVALID_S0;
  assign s_last   = sel_s_q ? RLAST_S1 : RLAST_S0;
  assign s_id     = sel_s_q ? RID_S1[3:0] : RID_S0[3:0];
  assign s_data   = sel_s_q ? RDATA_S1 : RDATA_S0;
  assign s_resp   = sel_s_q ? RRESP_S1 : RRESP_S0;
  assign push     = s_rdy && s_vld;
  assign last_int = (cnt_q == len_q);

  assign head  = buf_q[rp_q];
  assign m_vld = busy && !empty;
  assign m_rdy = sel_m_q ? RREADY_M1 : RREADY_M0;
  assign pop   = m_vld && m_rdy;
  assign occ_d = occ_q + {1'b0, push} - {1'b0, pop};

  assign busy      = (state_q != IDLE);
  assign len_err   = err_q;
  assign RREADY_S0 = s_rdy && !sel_s_q;
  assign RREADY_S1 = s_rdy && sel_s_q;
  assign R_done_M0 = (state_q == DONE) && !sel_m_q;
  assign R_done_M1 = (state_q == DONE) && sel_m_q;

  // Every field is masked so an idle or unselected master sees all zeros.
  assign m0_on     = m_vld && !sel_m_q;
  assign m1_on     = m_vld && sel_m_q;
  assign RVALID_M0 = m0_on;
  assign RID_M0    = m0_on ? head.id : '0;
  assign RDATA_M0  = m0_on ? head.data : '0;
  assign RRESP_M0  = m0_on ? head.resp : '0;
  assign RLAST_M0  = m0_on && head.last;
  assign RVALID_M1 = m1_on;
  assign RID_M1    = m1_on ? head.id : '0;
  assign RDATA_M1  = m1_on ? head.data : '0;
  assign RRESP_M1  = m1_on ? head.resp : '0;
  assign RLAST_M1  = m1_on && head.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_s_q <= 1'b0;
      sel_m_q <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      occ_q   <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) wp_q <= ~wp_q;
      if (pop) rp_q <= ~rp_q;
      unique case (state_q)
        IDLE: begin
          if (ar_hs) begin
            sel_s_q <= ar_slave;
            sel_m_q <= (ar_id[7:4] == 4'd1);
            len_q   <= ar_len;
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (push) begin
            if (s_last != last_int) err_q <= 1'b1;
            // Counter parks at len so it never wraps.
            if (last_int) state_q <= DRAIN;
            else cnt_q <= cnt_q + 4'd1;
          end
        end
        DRAIN: begin
          if (pop && head.last) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wp_q] <= '{id: s_id, data: s_data, resp: s_resp, last: last_int};
    end
  end

endmodule

// File: tb/tb_read_data_router.sv
// Directed bench for read_data_router: routing, backpressure, length
// checking, reset mid-burst, ignored ar_hs and back-to-back bursts.
module tb_read_data_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ar_hs = 1'b0;
  logic        ar_slave = 1'b0;
  logic [7:0]  ar_id = '0;
  logic [3:0]  ar_len = '0;
  logic [7:0]  RID_S0 = '0, RID_S1 = '0;
  logic [31:0] RDATA_S0 = '0, RDATA_S1 = '0;
  logic [1:0]  RRESP_S0 = '0, RRESP_S1 = '0;
  logic        RLAST_S0 = 1'b0, RLAST_S1 = 1'b0;
  logic        RVALID_S0 = 1'b0, RVALID_S1 = 1'b0;
  logic        RREADY_S0, RREADY_S1;
  logic [3:0]  RID_M0, RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1;
  logic        RVALID_M0, RVALID_M1;
  logic        RREADY_M0 = 1'b0, RREADY_M1 = 1'b0;
  logic        R_done_M0, R_done_M1;
  logic        busy, len_err;

  int compared = 0;
  int mismatched = 0;

  read_data_router #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ar_hs(ar_hs), .ar_slave(ar_slave), .ar_id(ar_id), .ar_len(ar_len),
    .RID_S0(RID_S0), .RDATA_S0(RDATA_S0), .RRESP_S0(RRESP_S0),
    .RLAST_S0(RLAST_S0), .RVALID_S0(RVALID_S0), .RREADY_S0(RREADY_S0),
    .RID_S1(RID_S1), .RDATA_S1(RDATA_S1), .RRESP_S1(RRESP_S1),
    .RLAST_S1(RLAST_S1), .RVALID_S1(RVALID_S1), .RREADY_S1(RREADY_S1),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0),
    .RLAST_M0(RLAST_M0), .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1),
    .RLAST_M1(RLAST_M1), .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .R_done_M0(R_done_M0), .R_done_M1(R_done_M1),
    .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  wire [1:0] rs_w   = {RREADY_S1, RREADY_S0};
  wire [1:0] rv_w   = {RVALID_M1, RVALID_M0};
  wire [1:0] rl_w   = {RLAST_M1, RLAST_M0};
  wire [1:0] done_w = {R_done_M1, R_done_M0};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Selected slave gets the real beat; the other one shouts junk.
  task automatic drive(input logic s, input logic vld, input logic [7:0] id,
                       input logic [31:0] data, input logic last);
    RVALID_S0 = s ? 1'b1 : vld;
    RID_S0    = s ? 8'hEE : id;
    RDATA_S0  = s ? 32'hBAD0BAD0 : data;
    RRESP_S0  = s ? 2'b11 : data[1:0];
    RLAST_S0  = s ? 1'b1 : last;
    RVALID_S1 = s ? vld : 1'b1;
    RID_S1    = s ? id : 8'hEE;
    RDATA_S1  = s ? data : 32'hBAD0BAD0;
    RRESP_S1  = s ? data[1:0] : 2'b11;
    RLAST_S1  = s ? last : 1'b1;
  endtask

  task automatic idle_inputs();
    RVALID_S0 = 1'b0; RVALID_S1 = 1'b0;
    RLAST_S0 = 1'b0; RLAST_S1 = 1'b0;
    RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
    ar_hs = 1'b0;
  endtask

  task automatic ar(input logic s, input logic [7:0] id,
                    input logic [3:0] len);
    ar_hs = 1'b1; ar_slave = s; ar_id = id; ar_len = len;
    @(negedge clk);
    ar_hs = 1'b0;
  endtask

  // Per-cycle expectations: bit i of each mask, nibble i of ed (beat no.).
  task automatic burst(input logic s, input logic m, input logic [7:0] rid,
                       input int beats, input int early, input int n,
                       input logic [31:0] base, input logic [7:0] rdy,
                       input logic [7:0] ers, input logic [7:0] ev,
                       input logic [7:0] el, input logic [7:0] eerr,
                       input logic [31:0] ed, input logic spur);
    int b;
    logic acc;
    logic [3:0] nib;
    logic [31:0] xd;
    b = 1;
    for (int i = 0; i < n; i++) begin
      drive(s, b <= beats, rid, base + 32'(b),
            early != 0 ? (b == early) : (b == beats));
      if (m) begin RREADY_M1 = rdy[i]; RREADY_M0 = 1'b1; end
      else begin RREADY_M0 = rdy[i]; RREADY_M1 = 1'b1; end
      ar_hs = spur && (i == 0);
      ar_slave = ~s;
      ar_id = m ? 8'h02 : 8'h13;
      ar_len = 4'hF;
      #1;
      nib = ed[i*4 +: 4];
      xd = (nib == 4'd0) ? 32'd0 : base + 32'(nib);
      chk("rready_sel", rs_w[s], ers[i]);
      chk("rready_oth", rs_w[~s], 0);
      chk("rvalid_sel", rv_w[m], ev[i]);
      chk("rvalid_oth", rv_w[~m], 0);
      chk("rdata_sel", m ? RDATA_M1 : RDATA_M0, xd);
      chk("rdata_oth", m ? RDATA_M0 : RDATA_M1, 0);
      chk("rresp_sel", m ? RRESP_M1 : RRESP_M0, xd[1:0]);
      chk("rid_sel", m ? RID_M1 : RID_M0, ev[i] ? rid[3:0] : 4'h0);
      chk("rlast_sel", rl_w[m], el[i]);
      chk("len_err", len_err, eerr[i]);
      acc = rs_w[s] && (b <= beats);
      @(negedge clk);
      if (acc) b++;
    end
    ar_hs = 1'b0;
    #1;
    chk("done_sel", done_w[m], 1);
    chk("done_oth", done_w[~m], 0);
    chk("busy_done", busy, 1);
    chk("rvalid_done", rv_w, 0);
    idle_inputs();
    @(negedge clk);
    #1;
    chk("busy_after", busy, 0);
    chk("done_after", done_w, 0);
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rs", rs_w, 0);
    chk("rst_rv", rv_w, 0);
    chk("rst_err", len_err, 0);
    chk("rst_done", done_w, 0);

    // Single beat, M0 <- S0.
    ar(1'b0, 8'h03, 4'd0);
    burst(1'b0, 1'b0, 8'h03, 1, 0, 2, 32'hDEADBEEE, 8'b10, 8'b01,
          8'b10, 8'b10, 8'h00, 32'h10, 1'b0);

    // 4 beats, M1 <- S1, master ready 1,0,0,1,1,1.
    ar(1'b1, 8'h12, 4'd3);
    burst(1'b1, 1'b1, 8'h12, 4, 0, 7, 32'h0, 8'b0111_1001, 8'b0011_0011,
          8'b0111_1110, 8'b0100_0000, 8'h00, 32'h04321110, 1'b0);

    // Back-to-back, early slave RLAST on beat 2.
    ar(1'b0, 8'h05, 4'd3);
    burst(1'b0, 1'b0, 8'h05, 4, 2, 5, 32'h100, 8'hFF, 8'b0000_1111,
          8'b0001_1110, 8'b0001_0000, 8'b0001_1100, 32'h00043210, 1'b0);
    chk("err_sticky", len_err, 1);

    // Reset after two beats buffered.
    ar(1'b1, 8'h17, 4'd3);
    drive(1'b1, 1'b1, 8'h17, 32'h501, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 8'h17, 32'h502, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_full_rs", RREADY_S1, 0);
    chk("mid_rv", RVALID_M1, 1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_rv0", rv_w, 0);
    chk("mid_data", RDATA_M1, 0);
    chk("mid_rs0", rs_w, 0);
    chk("mid_err", len_err, 0);
    chk("mid_done", done_w, 0);
    ar(1'b1, 8'h17, 4'd0);
    burst(1'b1, 1'b1, 8'h17, 1, 0, 2, 32'h500, 8'b10, 8'b01,
          8'b10, 8'b10, 8'h00, 32'h10, 1'b0);

    // Spurious ar_hs during FILL towards the other slave and master.
    ar(1'b0, 8'h1A, 4'd1);
    burst(1'b0, 1'b1, 8'h1A, 2, 0, 3, 32'h700, 8'hFF, 8'b011,
          8'b110, 8'b100, 8'h00, 32'h210, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
